db_req_issuer: RTL and testbench
================================

Name: db_req_issuer

Overview:
Network-side requester for the key/value filter database. It accepts parsed flow tuples from the packet parser and packs each into a 96-bit key. It issues one lookup/update at a time over the database request handshake (key, flag, valid, ready) and waits for the database response (valid, flag). It returns a per-request result to the filtering pipeline and times out requests the database never answers.

Parameters:
KEY_SIZE, 96, database key width; packing below requires exactly 96.
FIFO_DEPTH, 4, tuple queue depth; power of 2, minimum 2.
TIMEOUT, 64, cycles spent in S_WAIT before a request is abandoned; minimum 2.

Ports:
clk  input  1  system clock (156.25 MHz network domain)
rst  input  1  asynchronous, active-high reset
db_init_done  input  1  high once database memory initialisation has completed
pkt_valid  input  1  tuple valid
pkt_ready  output  1  tuple accept; transfer occurs when pkt_valid and pkt_ready are both high
pkt_src_ip  input  32  source IPv4 address
pkt_dst_ip  input  32  destination IPv4 address
pkt_dst_port  input  16  destination UDP port
pkt_op  input  4  operation flag, forwarded unchanged
db_key  output  KEY_SIZE  request key
db_flag  output  4  request operation flag
db_valid  output  1  request strobe, single-cycle pulse
db_ready  input  1  database can accept a request
db_resp_valid  input  1  database response strobe
db_resp_flag  input  4  database response flag
res_valid  output  1  result strobe, single-cycle pulse
res_key  output  KEY_SIZE  key of the completed request
res_flag  output  4  response flag; 0 on timeout
res_timeout  output  1  result produced by timeout
cnt_req  output  32  requests issued
cnt_timeout  output  16  timeouts
cnt_stray  output  16  responses received outside S_WAIT

Behaviour:
- Reset: all outputs 0 except pkt_ready, which is 0 during reset; FIFO emptied; FSM in S_INIT; counters cleared. Reset mid-request abandons the request silently, with no res_valid.
- Key packing: {pkt_src_ip, pkt_dst_ip, pkt_dst_port, 16'h0000}, src_ip in the MSBs. pkt_op is stored alongside the key.
- FIFO:
  - pkt_ready = !full, combinational from registered pointers.
  - Push and pop in the same cycle is legal when neither full nor empty.
  - Pointers carry one extra wrap bit; full/empty are derived from pointer compare.
  - Tuples are accepted in S_INIT as well, so the FIFO fills.
- FSM states:
  - S_INIT: wait for db_init_done=1, then go to S_IDLE.
  - S_IDLE: if FIFO non-empty and db_ready=1, register the head key/flag onto db_key/db_flag, pop the FIFO, set db_valid=1, clear the timer, go to S_WAIT. Otherwise db_valid=0.
  - S_WAIT:
    - db_valid=0 from the first S_WAIT cycle; db_key/db_flag hold their values.
    - The timer increments every cycle.
    - On db_resp_valid: res_valid=1, res_flag=db_resp_flag, res_timeout=0, res_key=db_key, go to S_IDLE.
    - Else if timer==TIMEOUT-1: res_valid=1, res_flag=0, res_timeout=1, cnt_timeout+1, go to S_IDLE.
    - A response in the same cycle as expiry is a normal response (response wins).
- Only one request is outstanding. No new db_valid is issued in the cycle res_valid is high, so minimum spacing between db_valid pulses is 3 cycles.
- db_resp_valid while in S_INIT or S_IDLE: dropped, cnt_stray+1.
- db_init_done falling while in S_IDLE: return to S_INIT. In S_WAIT it is ignored until the request completes.
- Counters: cnt_req increments on each db_valid. All counters saturate at all-ones.
- Latency: tuple accepted in cycle N (FIFO empty, S_IDLE, db_ready=1) produces db_valid in cycle N+2. A response in cycle M produces res_valid in cycle M+1.
- res_* outputs are registered and hold until the next result. Only res_valid pulses.

Test Plan:
- Reset, db_init_done=0, push 4 tuples → pkt_ready drops after the 4th; db_valid stays 0. Raise db_init_done → 4 requests issue in FIFO order; cnt_req=4.
- Tuple src=0x0A000001, dst=0x0A000002, port=0x1F90, op=1, db_ready=1 → db_valid 2 cycles later with db_key=0x0A0000010A0000021F900000 and db_flag=1. Respond flag=3 three cycles later → res_valid next cycle, res_flag=3, res_timeout=0.
- No response → res_valid exactly TIMEOUT cycles after db_valid, with res_timeout=1, res_flag=0, cnt_timeout=1. The next queued request then issues.
- db_resp_valid asserted in the same cycle as timer expiry → res_timeout=0, res_flag=db_resp_flag, cnt_timeout unchanged.
- db_resp_valid pulsed while in S_IDLE → cnt_stray=1, no res_valid. Also check simultaneous push/pop with 2 entries keeps order and count.
- Assert rst while in S_WAIT → all outputs 0 asynchronously and FIFO empty. After release, no res_valid until a new tuple completes.

Source files
------------

// File: rtl/db_req_issuer_if.sv
// Purpose : bundles the tuple input, database request/response and result
//           handshakes of db_req_issuer into one interface.
// Ports   : master = the issuer (accepts tuples, drives db requests and results);
//           slave  = its environment (parser, database, filtering pipeline).
interface db_req_issuer_if #(
  parameter int KEY_SIZE = 96
);
  // parsed tuple from the packet parser
  logic                pkt_valid;
  logic                pkt_ready;
  logic [31:0]         pkt_src_ip;
  logic [31:0]         pkt_dst_ip;
  logic [15:0]         pkt_dst_port;
  logic [3:0]          pkt_op;

  // database request / response
  logic [KEY_SIZE-1:0] db_key;
  logic [3:0]          db_flag;
  logic                db_valid;
  logic                db_ready;
  logic                db_resp_valid;
  logic [3:0]          db_resp_flag;

  // per-request result toward the filtering pipeline
  logic                res_valid;
  logic [KEY_SIZE-1:0] res_key;
  logic [3:0]          res_flag;
  logic                res_timeout;

  modport master (
    input  pkt_valid, pkt_src_ip, pkt_dst_ip, pkt_dst_port, pkt_op,
    output pkt_ready,
    output db_key, db_flag, db_valid,
    input  db_ready, db_resp_valid, db_resp_flag,
    output res_valid, res_key, res_flag, res_timeout
  );

  modport slave (
    output pkt_valid, pkt_src_ip, pkt_dst_ip, pkt_dst_port, pkt_op,
    input  pkt_ready,
    input  db_key, db_flag, db_valid,
    output db_ready, db_resp_valid, db_resp_flag,
    input  res_valid, res_key, res_flag, res_timeout
  );
endinterface

// File: rtl/db_req_issuer.sv
// Purpose : queues parsed flow tuples, packs each into a 96-bit key and issues
//           one database lookup/update at a time, returning a result per request
//           (database response or timeout). Tuple accepted in cycle N reaches
//           db_valid in N+2; a response in cycle M gives res_valid in M+1.
// Ports   : clk/rst (async active-high), db_init_done, bus (tuple in, db request
//           out, db response in, result out), cnt_req/cnt_timeout/cnt_stray
//           saturating statistics. pkt_ready drops when the tuple queue is full.
module db_req_issuer #(
  parameter int KEY_SIZE   = 96,  // key packing below produces exactly 96 bits
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int TIMEOUT    = 64   // cycles in S_WAIT before abandoning, >= 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            db_init_done,
  db_req_issuer_if.master bus,
  output logic [31:0]     cnt_req,
  output logic [15:0]     cnt_timeout,
  output logic [15:0]     cnt_stray
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [KEY_SIZE-1:0] key;
    logic [3:0]          op;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Tuple queue: pointers carry an extra wrap bit so full/empty come from a
  // straight pointer compare.
  // ---------------------------------------------------------------------------
  entry_t      mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pkt_ready;
  logic        push;
  logic        pop;
  entry_t      head;
  entry_t      new_entry;

  state_t              state;
  logic [TW-1:0]       timer;
  logic                db_valid_q;
  logic [KEY_SIZE-1:0] db_key_q;
  logic [3:0]          db_flag_q;
  logic                res_valid_q;
  logic [KEY_SIZE-1:0] res_key_q;
  logic [3:0]          res_flag_q;
  logic                res_timeout_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Held low while reset is asserted so the parser cannot push into a queue
  // that is being cleared.
  assign pkt_ready     = !fifo_full && !rst;
  assign bus.pkt_ready = pkt_ready;
  assign push          = bus.pkt_valid && pkt_ready;

  assign new_entry.key = {bus.pkt_src_ip, bus.pkt_dst_ip, bus.pkt_dst_port, 16'h0000};
  assign new_entry.op  = bus.pkt_op;
  assign head          = mem[rd_ptr[AW-1:0]];

  // Issue condition. The !res_valid_q term keeps a new request out of the
  // cycle that reports the previous result, giving 3-cycle db_valid spacing.
  assign pop = (state == S_IDLE) && db_init_done && !fifo_empty &&
               bus.db_ready && !res_valid_q;

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM with registered outputs. Also owns the queue read pointer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_INIT;
      rd_ptr        <= '0;
      timer         <= '0;
      db_valid_q    <= 1'b0;
      db_key_q      <= '0;
      db_flag_q     <= '0;
      res_valid_q   <= 1'b0;
      res_key_q     <= '0;
      res_flag_q    <= '0;
      res_timeout_q <= 1'b0;
      cnt_req       <= '0;
      cnt_timeout   <= '0;
      cnt_stray     <= '0;
    end else begin
      // both strobes are single-cycle pulses
      db_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;

      case (state)
        S_INIT: begin
          if (bus.db_resp_valid && (cnt_stray != '1)) begin
            cnt_stray <= cnt_stray + 16'd1;
          end
          if (db_init_done) begin
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (bus.db_resp_valid && (cnt_stray != '1)) begin
            cnt_stray <= cnt_stray + 16'd1;
          end
          if (!db_init_done) begin
            state <= S_INIT;
          end else if (pop) begin
            db_key_q   <= head.key;
            db_flag_q  <= head.op;
            db_valid_q <= 1'b1;
            rd_ptr     <= rd_ptr + 1'b1;
            timer      <= '0;
            state      <= S_WAIT;
            if (cnt_req != '1) begin
              cnt_req <= cnt_req + 32'd1;
            end
          end
        end

        S_WAIT: begin
          timer <= timer + 1'b1;
          // A response arriving on the expiry cycle is still a normal response.
          if (bus.db_resp_valid) begin
            res_valid_q   <= 1'b1;
            res_key_q     <= db_key_q;
            res_flag_q    <= bus.db_resp_flag;
            res_timeout_q <= 1'b0;
            state         <= S_IDLE;
          end else if (timer == TIMER_LAST) begin
            res_valid_q   <= 1'b1;
            res_key_q     <= db_key_q;
            res_flag_q    <= 4'h0;
            res_timeout_q <= 1'b1;
            state         <= S_IDLE;
            if (cnt_timeout != '1) begin
              cnt_timeout <= cnt_timeout + 16'd1;
            end
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.db_valid    = db_valid_q;
  assign bus.db_key      = db_key_q;
  assign bus.db_flag     = db_flag_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_key     = res_key_q;
  assign bus.res_flag    = res_flag_q;
  assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_db_req_issuer.sv
module tb_db_req_issuer;
  localparam int KEY_SIZE   = 96;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        db_init_done;
  logic [31:0] cnt_req;
  logic [15:0] cnt_timeout;
  logic [15:0] cnt_stray;

  db_req_issuer_if #(.KEY_SIZE(KEY_SIZE)) bus();

  db_req_issuer #(
    .KEY_SIZE(KEY_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .db_init_done(db_init_done), .bus(bus),
    .cnt_req(cnt_req), .cnt_timeout(cnt_timeout), .cnt_stray(cnt_stray)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KEY_SIZE-1:0] key;
    logic [3:0]          flag;
  } req_t;

  typedef struct packed {
    logic [KEY_SIZE-1:0] key;
    logic [3:0]          flag;
    logic                timeout;
  } res_t;

  req_t exp_req_q[$];
  res_t exp_res_q[$];
  req_t exp_req;
  res_t exp_res;
  logic [KEY_SIZE-1:0] cur_key;   // key of the request the model believes is outstanding
  int n_checks = 0;
  int n_fail   = 0;

  // Every observation happens 1 ns after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one tuple for one cycle (caller ensures pkt_ready) and records the
  // request the model expects it to become.
  task automatic push_tuple(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] p, input logic [3:0] op);
    req_t r;
    bus.pkt_valid    = 1'b1;
    bus.pkt_src_ip   = s;
    bus.pkt_dst_ip   = d;
    bus.pkt_dst_port = p;
    bus.pkt_op       = op;
    r.key  = {s, d, p, 16'h0000};
    r.flag = op;
    exp_req_q.push_back(r);
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  // Drives a database response for the current cycle; records the result.
  task automatic respond(input logic [3:0] f);
    res_t r;
    bus.db_resp_valid = 1'b1;
    bus.db_resp_flag  = f;
    r.key     = cur_key;
    r.flag    = f;
    r.timeout = 1'b0;
    exp_res_q.push_back(r);
    tick();
    bus.db_resp_valid = 1'b0;
    bus.db_resp_flag  = 4'h0;
  endtask

  task automatic wait_db_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.db_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    db_init_done      = 1'b0;
    bus.pkt_valid     = 1'b0;
    bus.pkt_src_ip    = '0;
    bus.pkt_dst_ip    = '0;
    bus.pkt_dst_port  = '0;
    bus.pkt_op        = '0;
    bus.db_ready      = 1'b0;
    bus.db_resp_valid = 1'b0;
    bus.db_resp_flag  = '0;
    repeat (3) tick();
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_pkt_ready: got %b expected 0", bus.pkt_ready);
    end
    n_checks++;
    if ({bus.db_valid, bus.db_key, bus.db_flag} !== '0) begin
      n_fail++; $display("FAIL reset_db_outputs: got %b/%h/%h expected all 0", bus.db_valid, bus.db_key, bus.db_flag);
    end
    n_checks++;
    if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== '0) begin
      n_fail++; $display("FAIL reset_res_outputs: got %b/%h/%h/%b expected all 0", bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout);
    end
    n_checks++;
    if ({cnt_req, cnt_timeout, cnt_stray} !== 64'h0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", cnt_req, cnt_timeout, cnt_stray);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.pkt_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_pkt_ready: got %b expected 1", bus.pkt_ready);
    end
  endtask

  // Queue fills while the database is still initialising, then drains in order.
  task automatic test_fill_init();
    bit ok;
    bit saw_valid;
    bus.db_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_tuple(32'hC0A80001 + i, 32'h0A0000FF - i, 16'h1000 + 16'(i), 4'(i + 2));
    end
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_pkt_ready: got %b expected 0 after 4 pushes", bus.pkt_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.db_valid !== 1'b0) saw_valid = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++; $display("FAIL init_no_issue: db_valid seen=%b expected 0 before db_init_done", saw_valid);
    end
    db_init_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_db_valid(12, ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL fill_issue_%0d: db_valid=0 expected 1 within 12 cycles", i);
        return;
      end
      exp_req = exp_req_q.pop_front();
      cur_key = exp_req.key;
      n_checks++;
      if ({bus.db_key, bus.db_flag} !== exp_req) begin
        n_fail++; $display("FAIL fill_order_%0d: got %h/%h expected %h/%h", i, bus.db_key, bus.db_flag, exp_req.key, exp_req.flag);
      end
      tick();
      respond(4'(i + 8));
      exp_res = exp_res_q.pop_front();
      n_checks++;
      if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== {1'b1, exp_res}) begin
        n_fail++; $display("FAIL fill_res_%0d: got v=%b %h/%h/%b expected v=1 %h/%h/%b", i, bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout, exp_res.key, exp_res.flag, exp_res.timeout);
      end
    end
    n_checks++;
    if (cnt_req !== 32'd4) begin
      n_fail++; $display("FAIL fill_cnt_req: got %0d expected 4", cnt_req);
    end
  endtask

  task automatic test_basic();
    repeat (2) tick();
    push_tuple(32'h0A000001, 32'h0A000002, 16'h1F90, 4'h1);
    n_checks++;
    if (bus.db_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency_n1: db_valid=%b expected 0", bus.db_valid);
    end
    tick();
    exp_req = exp_req_q.pop_front();
    cur_key = exp_req.key;
    n_checks++;
    if ({bus.db_valid, bus.db_key, bus.db_flag} !== {1'b1, 96'h0A0000010A0000021F900000, 4'h1}) begin
      n_fail++; $display("FAIL basic_key: got v=%b %h/%h expected v=1 0a0000010a0000021f900000/1", bus.db_valid, bus.db_key, bus.db_flag);
    end
    n_checks++;
    if ({bus.db_key, bus.db_flag} !== exp_req) begin
      n_fail++; $display("FAIL basic_scoreboard: got %h/%h expected %h/%h", bus.db_key, bus.db_flag, exp_req.key, exp_req.flag);
    end
    repeat (3) tick();
    respond(4'h3);
    exp_res = exp_res_q.pop_front();
    n_checks++;
    if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== {1'b1, exp_res}) begin
      n_fail++; $display("FAIL basic_res: got v=%b %h/%h/%b expected v=1 %h/%h/%b", bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout, exp_res.key, exp_res.flag, exp_res.timeout);
    end
    tick();
    n_checks++;
    if ({bus.res_valid, bus.res_flag} !== {1'b0, 4'h3}) begin
      n_fail++; $display("FAIL basic_res_hold: got v=%b flag=%h expected v=0 flag=3", bus.res_valid, bus.res_flag);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    res_t r;
    repeat (2) tick();
    push_tuple(32'h11111111, 32'h22222222, 16'h0035, 4'h6);
    wait_db_valid(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL timeout_issue: db_valid=0 expected 1 within 10 cycles");
      return;
    end
    exp_req = exp_req_q.pop_front();
    cur_key = exp_req.key;
    r.key = cur_key; r.flag = 4'h0; r.timeout = 1'b1;
    exp_res_q.push_back(r);
    // queue a second tuple while the first one is outstanding
    push_tuple(32'h33333333, 32'h44444444, 16'h0050, 4'h9);
    cyc = 1;
    while (bus.res_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== TIMEOUT) begin
      n_fail++; $display("FAIL timeout_cycles: res_valid after %0d cycles expected %0d", cyc, TIMEOUT);
    end
    exp_res = exp_res_q.pop_front();
    n_checks++;
    if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== {1'b1, exp_res}) begin
      n_fail++; $display("FAIL timeout_res: got v=%b %h/%h/%b expected v=1 %h/%h/%b", bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout, exp_res.key, exp_res.flag, exp_res.timeout);
    end
    n_checks++;
    if (cnt_timeout !== 16'd1) begin
      n_fail++; $display("FAIL timeout_cnt: got %0d expected 1", cnt_timeout);
    end
    wait_db_valid(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL timeout_next_issue: db_valid=0 expected 1 within 10 cycles");
      return;
    end
    exp_req = exp_req_q.pop_front();
    cur_key = exp_req.key;
    n_checks++;
    if ({bus.db_key, bus.db_flag} !== exp_req) begin
      n_fail++; $display("FAIL timeout_next_req: got %h/%h expected %h/%h", bus.db_key, bus.db_flag, exp_req.key, exp_req.flag);
    end
    tick();
    respond(4'h4);
    exp_res = exp_res_q.pop_front();
    n_checks++;
    if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== {1'b1, exp_res}) begin
      n_fail++; $display("FAIL timeout_next_res: got v=%b %h/%h/%b expected v=1 %h/%h/%b", bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout, exp_res.key, exp_res.flag, exp_res.timeout);
    end
  endtask

  // Response lands exactly on the last timer cycle: it must count as a response.
  task automatic test_resp_at_expiry();
    bit ok;
    repeat (2) tick();
    push_tuple(32'hAABBCCDD, 32'h01020304, 16'hBEEF, 4'hE);
    wait_db_valid(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL expiry_issue: db_valid=0 expected 1 within 10 cycles");
      return;
    end
    exp_req = exp_req_q.pop_front();
    cur_key = exp_req.key;
    repeat (TIMEOUT - 1) tick();
    respond(4'h5);
    exp_res = exp_res_q.pop_front();
    n_checks++;
    if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== {1'b1, exp_res}) begin
      n_fail++; $display("FAIL expiry_res: got v=%b %h/%h/%b expected v=1 %h/%h/%b", bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout, exp_res.key, exp_res.flag, exp_res.timeout);
    end
    n_checks++;
    if (cnt_timeout !== 16'd1) begin
      n_fail++; $display("FAIL expiry_cnt_timeout: got %0d expected 1", cnt_timeout);
    end
  endtask

  task automatic test_stray();
    repeat (3) tick();
    bus.db_resp_valid = 1'b1;
    bus.db_resp_flag  = 4'h7;
    tick();
    bus.db_resp_valid = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL stray_res_valid: got %b expected 0", bus.res_valid);
    end
    tick();
    n_checks++;
    if ({cnt_stray, bus.res_valid} !== {16'd1, 1'b0}) begin
      n_fail++; $display("FAIL stray_cnt: got cnt=%0d res_valid=%b expected cnt=1 res_valid=0", cnt_stray, bus.res_valid);
    end
  endtask

  // Two entries queued, then a push and a pop land in the same cycle.
  task automatic test_back_to_back();
    bit ok;
    logic [31:0] req_before;
    repeat (2) tick();
    req_before   = cnt_req;
    bus.db_ready = 1'b0;
    push_tuple(32'h0000A001, 32'h0000B001, 16'h0001, 4'h1);
    push_tuple(32'h0000A002, 32'h0000B002, 16'h0002, 4'h2);
    tick();
    n_checks++;
    if (bus.db_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_hold: db_valid=%b expected 0 with db_ready=0", bus.db_valid);
    end
    bus.db_ready = 1'b1;
    push_tuple(32'h0000A003, 32'h0000B003, 16'h0003, 4'h3);
    ok = (bus.db_valid === 1'b1);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) wait_db_valid(12, ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL b2b_issue_%0d: db_valid=0 expected 1", j);
        return;
      end
      exp_req = exp_req_q.pop_front();
      cur_key = exp_req.key;
      n_checks++;
      if ({bus.db_key, bus.db_flag} !== exp_req) begin
        n_fail++; $display("FAIL b2b_order_%0d: got %h/%h expected %h/%h", j, bus.db_key, bus.db_flag, exp_req.key, exp_req.flag);
      end
      tick();
      respond(4'(j + 12));
      exp_res = exp_res_q.pop_front();
      n_checks++;
      if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== {1'b1, exp_res}) begin
        n_fail++; $display("FAIL b2b_res_%0d: got v=%b %h/%h/%b expected v=1 %h/%h/%b", j, bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout, exp_res.key, exp_res.flag, exp_res.timeout);
      end
    end
    wait_db_valid(10, ok);
    n_checks++;
    if (ok !== 1'b0 || cnt_req !== req_before + 32'd3) begin
      n_fail++; $display("FAIL b2b_count: extra issue=%b cnt_req delta=%0d expected 0 and 3", ok, cnt_req - req_before);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    bit saw;
    repeat (2) tick();
    push_tuple(32'h0BAD0001, 32'h0BAD0002, 16'h0BAD, 4'hA);
    push_tuple(32'h0BAD0003, 32'h0BAD0004, 16'h0BAD, 4'hB);
    n_checks++;
    if (bus.db_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstwait_pre: db_valid=%b expected 1", bus.db_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.db_valid, bus.db_key, bus.db_flag, bus.pkt_ready, cnt_req} !== '0) begin
      n_fail++; $display("FAIL rstwait_async: got v=%b key=%h flag=%h rdy=%b req=%0d expected all 0", bus.db_valid, bus.db_key, bus.db_flag, bus.pkt_ready, cnt_req);
    end
    exp_req_q.delete();
    exp_res_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.db_valid !== 1'b0 || bus.res_valid !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_quiet: activity seen=%b expected 0 (queue must be empty)", saw);
    end
    push_tuple(32'h600D0001, 32'h600D0002, 16'h600D, 4'hC);
    wait_db_valid(12, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rstwait_issue: db_valid=0 expected 1 within 12 cycles");
      return;
    end
    exp_req = exp_req_q.pop_front();
    cur_key = exp_req.key;
    n_checks++;
    if ({bus.db_key, bus.db_flag, cnt_req} !== {exp_req, 32'd1}) begin
      n_fail++; $display("FAIL rstwait_req: got %h/%h req=%0d expected %h/%h req=1", bus.db_key, bus.db_flag, cnt_req, exp_req.key, exp_req.flag);
    end
    tick();
    respond(4'h2);
    exp_res = exp_res_q.pop_front();
    n_checks++;
    if ({bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout} !== {1'b1, exp_res}) begin
      n_fail++; $display("FAIL rstwait_res: got v=%b %h/%h/%b expected v=1 %h/%h/%b", bus.res_valid, bus.res_key, bus.res_flag, bus.res_timeout, exp_res.key, exp_res.flag, exp_res.timeout);
    end
  endtask

  initial begin
    test_reset();
    test_fill_init();
    test_basic();
    test_timeout();
    test_resp_at_expiry();
    test_stray();
    test_back_to_back();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
